iram_arbiter: RTL and testbench

- Shares the single synchronous-read instruction RAM port among NUM_CORES core fetch units.
- Round-robin arbitration with at most one grant per cycle.
- Each fetch completes with a fixed latency of 2 cycles from grant.
- Returned words are held in per-core registers and stay stable until that core's next fetch. Sits between the core fetch stages and the IRAM instance.

---
 rtl/iram_arbiter.sv | 90 +++++++++
 tb/tb_iram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read IRAM port among NUM_CORES fetch units.
// Grant is combinational; the returned word lands in a per-core holding register two cycles later.
module iram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_en,
  input  logic [NUM_CORES-1:0]    req,
  input  logic [NUM_CORES*AW-1:0] req_addr,
  output logic [NUM_CORES-1:0]    gnt,
  output logic [NUM_CORES-1:0]    rvalid,
  output logic [NUM_CORES*DW-1:0] rdata,
  output logic [AW-1:0]           iram_addr,
  input  logic [DW-1:0]           iram_data,
  output logic [15:0]             conflict_cnt
);

  localparam int IW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]    w_elig;
  logic                    w_found;
  logic                    w_grant;
  logic                    w_multi;
  logic [IW-1:0]           w_win;
  logic [IW:0]             w_idx;

  logic [IW-1:0]           r_rr_ptr;
  logic                    r_s1_vld;
  logic [IW-1:0]           r_s1_id;
  logic [AW-1:0]           r_addr;
  logic [NUM_CORES-1:0]    r_rvalid;
  logic [NUM_CORES*DW-1:0] r_rdata;
  logic [15:0]             r_cnt;

  assign w_elig = req & core_en;

  // Scan from r_rr_ptr upward with wrap; first eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_CORES)) w_idx = w_idx - (IW+1)'(NUM_CORES);
      if (!w_found && w_elig[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  assign w_grant   = w_found & rst_n;
  assign gnt       = w_grant ? (NUM_CORES'(1) << w_win) : '0;
  // Idle cycles replay the last granted address so the RAM port never sees junk.
  assign iram_addr = w_grant ? req_addr[w_win*AW +: AW] : r_addr;
  assign w_multi   = |(w_elig & (w_elig - NUM_CORES'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_addr   <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= (w_win == IW'(NUM_CORES-1)) ? '0 : w_win + IW'(1);
        r_addr   <= iram_addr;
      end
      r_s1_vld <= w_grant;
      r_s1_id  <= w_win;
      r_rvalid <= '0;
      if (r_s1_vld) begin
        r_rvalid[r_s1_id]            <= 1'b1;
        r_rdata[r_s1_id*DW +: DW]    <= iram_data;
      end
      if (w_multi && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign rvalid       = r_rvalid;
  assign rdata        = r_rdata;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: directed vector table, hand-written reset/saturation sequences,
// and random traffic, all checked every cycle against a behavioural arbiter/IRAM model.
module tb_iram_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      core_en = '0;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [N*DW-1:0]   rdata;
  logic [AW-1:0]     iram_addr;
  logic [DW-1:0]     iram_data;
  logic [15:0]       conflict_cnt;

  iram_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .core_en(core_en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .iram_addr(iram_addr),
    .iram_data(iram_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read IRAM: data for the address sampled at an edge appears after it.
  logic [DW-1:0] ram [256];
  always @(posedge clk) iram_data <= ram[iram_addr[7:0]];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           m_ptr;
  int           m_cnt;
  logic [AW-1:0] m_last;
  logic [N-1:0]  m_rvalid;
  logic [DW-1:0] m_rd [N];
  bit            p_vld;
  int            p_id;
  logic [AW-1:0] p_addr;

  typedef struct {
    bit            rst_before;
    logic [N-1:0]  en;
    logic [N-1:0]  rq;
    logic [N*AW-1:0] ad;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [N-1:0]  erv;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [3:0] en, logic [3:0] rq, logic [63:0] ad,
                              logic [3:0] eg, logic [15:0] ea, logic [3:0] erv);
    vec_t v;
    v.rst_before = r; v.en = en; v.rq = rq; v.ad = ad; v.eg = eg; v.ea = ea; v.erv = erv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(logic [N-1:0] el);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_last = '0; m_rvalid = '0; p_vld = 0; p_id = 0; p_addr = '0;
    for (int i = 0; i < N; i++) m_rd[i] = '0;
  endtask

  // One clock cycle: check mid-cycle against the model, then advance the model across the edge.
  task automatic cyc(input bit tv = 0, input logic [3:0] teg = 0,
                     input logic [15:0] tea = 0, input logic [3:0] terv = 0,
                     input string tn = "");
    logic [N-1:0]    el, eg;
    logic [AW-1:0]   ea;
    logic [N*DW-1:0] rdflat;
    int w;
    @(negedge clk);
    el = req & core_en;
    w  = winner(el);
    eg = '0;
    ea = m_last;
    if (w >= 0) begin
      eg = N'(1) << w;
      ea = req_addr[w*AW +: AW];
    end
    for (int i = 0; i < N; i++) rdflat[i*DW +: DW] = m_rd[i];
    chk("gnt", 64'(gnt), 64'(eg));
    chk("iram_addr", 64'(iram_addr), 64'(ea));
    chk("rvalid", 64'(rvalid), 64'(m_rvalid));
    chk("rdata", 64'(rdata), 64'(rdflat));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (tv) begin
      chk({tn, "_gnt"}, 64'(gnt), 64'(teg));
      chk({tn, "_addr"}, 64'(iram_addr), 64'(tea));
      chk({tn, "_rvalid"}, 64'(rvalid), 64'(terv));
    end
    m_rvalid = '0;
    if (p_vld) begin
      m_rvalid[p_id] = 1'b1;
      m_rd[p_id]     = ram[p_addr[7:0]];
    end
    p_vld = (w >= 0);
    if (w >= 0) begin
      p_id = w; p_addr = ea; m_last = ea; m_ptr = (w + 1) % N;
    end
    if ($countones(el) >= 2 && m_cnt < 65535) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_gnt"}, 64'(gnt), 64'(0));
    chk({nm, "_rvalid"}, 64'(rvalid), 64'(0));
    chk({nm, "_rdata"}, 64'(rdata), 64'(0));
    chk({nm, "_iram_addr"}, 64'(iram_addr), 64'(0));
    chk({nm, "_cnt"}, 64'(conflict_cnt), 64'(0));
  endtask

  // Reset with every core requesting, so a forced-zero grant is actually exercised.
  task automatic do_reset();
    core_en = '1; req = '1; req_addr = 64'h0003_0002_0001_0000;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 13 + 100);
    ram[0] = 16'd35; ram[1] = 16'd7; ram[3] = 16'd5;

    // core0 alone, addr 3
    tbl.push_back(mk(1, 4'hF, 4'b0001, 64'h0000_0000_0000_0003, 4'b0001, 16'd3, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0000_0003, 4'b0000, 16'd3, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0000_0003, 4'b0000, 16'd3, 4'b0001));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0000_0003, 4'b0000, 16'd3, 4'b0000));
    // all cores, addrs 0..3
    tbl.push_back(mk(1, 4'hF, 4'hF, 64'h0003_0002_0001_0000, 4'b0001, 16'd0, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'hF, 64'h0003_0002_0001_0000, 4'b0010, 16'd1, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'hF, 64'h0003_0002_0001_0000, 4'b0100, 16'd2, 4'b0001));
    tbl.push_back(mk(0, 4'hF, 4'hF, 64'h0003_0002_0001_0000, 4'b1000, 16'd3, 4'b0010));
    tbl.push_back(mk(0, 4'hF, 4'hF, 64'h0003_0002_0001_0000, 4'b0001, 16'd0, 4'b0100));
    tbl.push_back(mk(0, 4'hF, 4'h0, 64'h0003_0002_0001_0000, 4'b0000, 16'd0, 4'b1000));
    tbl.push_back(mk(0, 4'hF, 4'h0, 64'h0003_0002_0001_0000, 4'b0000, 16'd0, 4'b0001));
    tbl.push_back(mk(0, 4'hF, 4'h0, 64'h0003_0002_0001_0000, 4'b0000, 16'd0, 4'b0000));
    // core2 disabled
    tbl.push_back(mk(1, 4'hB, 4'hF, 64'h0003_0002_0001_0000, 4'b0001, 16'd0, 4'b0000));
    tbl.push_back(mk(0, 4'hB, 4'hF, 64'h0003_0002_0001_0000, 4'b0010, 16'd1, 4'b0000));
    tbl.push_back(mk(0, 4'hB, 4'hF, 64'h0003_0002_0001_0000, 4'b1000, 16'd3, 4'b0001));
    tbl.push_back(mk(0, 4'hB, 4'hF, 64'h0003_0002_0001_0000, 4'b0001, 16'd0, 4'b0010));
    tbl.push_back(mk(0, 4'hB, 4'hF, 64'h0003_0002_0001_0000, 4'b0010, 16'd1, 4'b1000));
    tbl.push_back(mk(0, 4'hB, 4'h0, 64'h0003_0002_0001_0000, 4'b0000, 16'd1, 4'b0001));
    tbl.push_back(mk(0, 4'hB, 4'h0, 64'h0003_0002_0001_0000, 4'b0000, 16'd1, 4'b0010));
    // core1 alone, then idle hold
    tbl.push_back(mk(1, 4'hF, 4'b0010, 64'h0000_0000_0001_0000, 4'b0010, 16'd1, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0001_0000, 4'b0000, 16'd1, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0001_0000, 4'b0000, 16'd1, 4'b0010));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0000_0001_0000, 4'b0000, 16'd1, 4'b0000));
    // same core back-to-back with a new address
    tbl.push_back(mk(1, 4'hF, 4'b0100, 64'h0000_0000_0000_0000, 4'b0100, 16'd0, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0100, 64'h0000_0001_0000_0000, 4'b0100, 16'd1, 4'b0000));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0001_0000_0000, 4'b0000, 16'd1, 4'b0100));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0001_0000_0000, 4'b0000, 16'd1, 4'b0100));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 64'h0000_0001_0000_0000, 4'b0000, 16'd1, 4'b0000));
    // core_en drops while the read is in flight
    tbl.push_back(mk(1, 4'hF, 4'b0001, 64'h0000_0000_0000_0003, 4'b0001, 16'd3, 4'b0000));
    tbl.push_back(mk(0, 4'h0, 4'b0001, 64'h0000_0000_0000_0003, 4'b0000, 16'd3, 4'b0000));
    tbl.push_back(mk(0, 4'h0, 4'b0000, 64'h0000_0000_0000_0003, 4'b0000, 16'd3, 4'b0001));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      core_en = tbl[i].en; req = tbl[i].rq; req_addr = tbl[i].ad;
      cyc(1, tbl[i].eg, tbl[i].ea, tbl[i].erv, $sformatf("vec%0d", i));
    end

    // Reset lands while a core1 read is in flight: it must be dropped.
    do_reset();
    core_en = '1; req = 4'b0010; req_addr = 64'h0000_0000_0001_0000;
    cyc(1, 4'b0010, 16'd1, 4'b0000, "midrst_grant");
    req = '1; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("midrst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = '0;
    cyc(1, 4'b0000, 16'd0, 4'b0000, "midrst_t2");
    cyc(1, 4'b0000, 16'd0, 4'b0000, "midrst_t3");
    req = '1; req_addr = 64'h0003_0002_0001_0000;
    cyc(1, 4'b0001, 16'd0, 4'b0000, "midrst_first");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      core_en  = N'($urandom | $urandom);
      req      = N'($urandom);
      req_addr = {$urandom, $urandom};
      cyc();
    end

    // Conflict counter saturation.
    do_reset();
    core_en = '1; req = '1; req_addr = 64'h0003_0002_0001_0000;
    repeat (65540) cyc();
    chk("cnt_sat", 64'(conflict_cnt), 64'h0000_0000_0000_FFFF);
    cyc();
    chk("cnt_sat_hold", 64'(conflict_cnt), 64'h0000_0000_0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
